// File: rtl/video_scanout.sv
// video_scanout: replays a 160x240 framebuffer of 7-bit colour indices as a 640x480@60 raster.
// Optional macro SCANOUT_LINEBUF_EN: odd output lines replay a row from an internal line buffer.
module video_scanout #(
  parameter int unsigned FB_WIDTH   = 160,
  parameter int unsigned FB_HEIGHT  = 240,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  fb_rd,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic [6:0]            fb_data,
  output logic [6:0]            vid_pix,
  output logic                  vid_de,
  output logic                  vid_hsync,
  output logic                  vid_vsync,
  output logic                  vid_frame
);

  localparam logic [9:0] HLast      = 10'd799;
  localparam logic [9:0] VLast      = 10'd524;
  localparam logic [9:0] HVis       = 10'(FB_WIDTH * 4);
  localparam logic [9:0] VVis       = 10'(FB_HEIGHT * 2);
  localparam logic [9:0] HSyncStart = 10'd656;
  localparam logic [9:0] HSyncEnd   = 10'd751;
  localparam logic [9:0] VSyncStart = 10'd490;
  localparam logic [9:0] VSyncEnd   = 10'd491;

  logic [9:0]  hcount_q, vcount_q;
  logic        visible, fetch, fetch_rd, hsync_n, vsync_n, frame_start;
  logic [7:0]  row, col;
  logic [17:0] addr_full;

  // Stage 1 and 2 carry the raster timing alongside the RAM access.
  logic de1_q, hs1_q, vs1_q, fr1_q, fetch1_q;
  logic de2_q, hs2_q, vs2_q, fr2_q, fetch2_q;
  logic [6:0] pix_q, src;

  always_comb begin
    visible     = (hcount_q < HVis) && (vcount_q < VVis);
    fetch       = visible && (hcount_q[1:0] == 2'b00);
    hsync_n     = !((hcount_q >= HSyncStart) && (hcount_q <= HSyncEnd));
    vsync_n     = !((vcount_q >= VSyncStart) && (vcount_q <= VSyncEnd));
    frame_start = (hcount_q == 10'd0) && (vcount_q == 10'd0);
    row         = vcount_q[8:1];
    col         = hcount_q[9:2];
    // row*160 as (row<<7)+(row<<5).
    addr_full   = {3'b0, row, 7'b0} + {5'b0, row, 5'b0} + {10'b0, col};
`ifdef SCANOUT_LINEBUF_EN
    fetch_rd    = fetch && !vcount_q[0];
`else
    fetch_rd    = fetch;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
    end else if (hcount_q == HLast) begin
      hcount_q <= 10'd0;
      vcount_q <= (vcount_q == VLast) ? 10'd0 : vcount_q + 10'd1;
    end else begin
      hcount_q <= hcount_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fb_rd    <= 1'b0;
      fb_addr  <= '0;
      de1_q    <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      fr1_q    <= 1'b0;
      fetch1_q <= 1'b0;
      de2_q    <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      fr2_q    <= 1'b0;
      fetch2_q <= 1'b0;
    end else begin
      fb_rd    <= fetch_rd;
      if (fetch_rd) fb_addr <= ADDR_WIDTH'(addr_full);
      de1_q    <= visible;
      hs1_q    <= hsync_n;
      vs1_q    <= vsync_n;
      fr1_q    <= frame_start;
      fetch1_q <= fetch;
      de2_q    <= de1_q;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      fr2_q    <= fr1_q;
      fetch2_q <= fetch1_q;
    end
  end

`ifdef SCANOUT_LINEBUF_EN
  logic [6:0] linebuf [FB_WIDTH];
  logic [7:0] col1_q, col2_q;
  logic       odd1_q, odd2_q;
  logic [6:0] lb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col1_q <= 8'd0;
      col2_q <= 8'd0;
      odd1_q <= 1'b0;
      odd2_q <= 1'b0;
      lb_q   <= 7'd0;
    end else begin
      // Column only moves on fetches so the buffer is never indexed past its end.
      if (fetch) col1_q <= col;
      odd1_q <= vcount_q[0];
      col2_q <= col1_q;
      odd2_q <= odd1_q;
      lb_q   <= linebuf[col1_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (fetch2_q && !odd2_q) linebuf[col2_q] <= fb_data;
  end

  always_comb src = odd2_q ? lb_q : fb_data;
`else
  always_comb src = fb_data;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_q     <= 7'd0;
      vid_pix   <= 7'd0;
      vid_de    <= 1'b0;
      vid_hsync <= 1'b1;
      vid_vsync <= 1'b1;
      vid_frame <= 1'b0;
    end else begin
      if (fetch2_q) pix_q <= src;
      vid_pix   <= !de2_q ? 7'd0 : (fetch2_q ? src : pix_q);
      vid_de    <= de2_q;
      vid_hsync <= hs2_q;
      vid_vsync <= vs2_q;
      vid_frame <= fr2_q;
    end
  end

endmodule

// File: doc/video_scanout.md
# video_scanout

Reads the 160x240 framebuffer filled by the TIA video writer, holding 7-bit colour indices, and replays it as a 640x480@60 raster. Each source pixel is drawn 4x horizontally and 2x vertically. The block sits between the framebuffer RAM read port and the downstream palette/encoder stage (HDMI/VGA). It issues framebuffer reads, generates sync and data-enable, and emits one colour index per pixel clock.

## Interface
- FB_WIDTH, 160: source pixels per line.
- FB_HEIGHT, 240: source lines.
- ADDR_WIDTH, 16: framebuffer address width.
- clk_i  in  1  pixel clock (25 MHz). The only clock.
- rst_i  in  1  synchronous, active-high reset.
- fb_rd  out  1  framebuffer read strobe, registered.
- fb_addr  out  ADDR_WIDTH  read address, registered. Equals row*160+col.
- fb_data  in  7  read data. Valid the cycle after the RAM samples fb_rd/fb_addr (synchronous RAM, 1-cycle latency).
- vid_pix  out  7  colour index. 0 when vid_de is low.
- vid_de  out  1  active-video enable.
- vid_hsync  out  1  horizontal sync, active low.
- vid_vsync  out  1  vertical sync, active low.
- vid_frame  out  1  one-cycle pulse marking output pixel (0,0).

## Operation
- Counters: hcount 0..799, vcount 0..524. hcount wraps 799->0 and advances vcount. vcount wraps 524->0.
- Horizontal regions: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical regions: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- Fetch condition: hcount<640, vcount<480 and hcount[1:0]==0.
  - Source column = hcount>>2 (0..159).
  - Source row = vcount>>1 (0..239).
  - Address = row*160+col, truncated to ADDR_WIDTH. Maximum 38399.
- Pixel latch: loads fb_data once per fetch and holds it for 4 output pixels.
- Outside the visible area: fb_rd=0, fb_addr holds its last value, vid_pix=0.
- Sync/DE pipeline: vid_de, vid_hsync, vid_vsync and vid_frame come from the counters through the same pipeline depth as the pixel path, so all outputs are aligned.
- Arithmetic: row*160 is computed as (row<<7)+(row<<5). No multiplier is required.

## Timing
- Reset values (cycle after rst_i sampled high): hcount=0, vcount=0, fb_rd=0, fb_addr=0, vid_pix=0, vid_de=0, vid_hsync=1, vid_vsync=1, vid_frame=0. Pipeline stages cleared.
- Reset mid-frame: the current frame is aborted with no partial pixels. The raster restarts at (0,0) on the first cycle rst_i is low.
- Pipeline for counter position (h,v) at edge E0:
  - fb_rd/fb_addr registered at E1.
  - RAM data valid after E2.
  - vid_pix/vid_de/sync registered at E3.
  - Output latency from counter to pins is 3 cycles in all modes.
- vid_hsync is low for exactly 96 cycles per line.
- vid_vsync is low for exactly 2 lines (1600 cycles), beginning at output line 490, hcount 0.
- vid_frame is high for 1 cycle every 420000 cycles, coincident with the first vid_de=1 cycle of the frame.
- vid_de is high 640 consecutive cycles per visible line, for 480 lines.
- fb_rd is a single-cycle strobe every 4th cycle during visible fetches. fb_data is never required to be held.

## Configuration
- Macro SCANOUT_LINEBUF_EN.
- Defined: a 160x7 internal line buffer is compiled in.
  - Even output lines (vcount[0]==0): fetch from the framebuffer and write each word into linebuf[col] as it returns.
  - Odd output lines: read linebuf[col], with one extra register stage matching RAM latency. fb_rd stays 0 for the whole line.
  - Framebuffer reads per frame: 38400.
- Undefined: no line buffer. Both output lines of each source row fetch from the framebuffer. Framebuffer reads per frame: 76800.
- Output latency, sync timing and vid_pix values are identical in both builds.

## Test plan
- Reset: assert rst_i mid-line (hcount=300, vcount=100) for 1 cycle.
  - Next cycle: vid_de=0, hsync=vsync=1, fb_rd=0.
  - vid_frame pulses 3 cycles after release, and vid_de rises in that same cycle.
- Line timing: count cycles over one line.
  - vid_de high 640 cycles.
  - hsync falls 16 cycles after vid_de falls, stays low 96 cycles.
  - Line period 800 cycles.
- Address sequence: framebuffer model returns data = addr[6:0].
  - Output line 0 shows indices 0,0,0,0,1,1,1,1,...,0x1F (for col 159).
  - Output line 2 begins with fb_addr=160.
  - Last fetch of line 479 is fb_addr=38399.
- Latency: first fb_rd of a frame at cycle N -> vid_pix equals fb_data[N+2 sample] at cycle N+2 output edge, i.e. 3 cycles after the fetch counter position. vid_de=1 in that same cycle.
- Line buffer (SCANOUT_LINEBUF_EN defined):
  - fb_rd pulses 160 times on even lines and 0 on odd lines.
  - Odd-line vid_pix is identical to the preceding even line even if framebuffer contents change in between.
  - Undefined build: 160 pulses on every visible line.
- Vertical: vid_vsync is low exactly for lines 490-491. vid_frame period is 420000 cycles over 3 consecutive frames.
